// File: rtl/lea_round_unit.sv
// One LEA-128 encryption round on a single time-shared 32-bit ripple-carry adder.
// Latency 4 cycles from START to DONE; START is ignored while BUSY, inputs are captured at START.
module lea_round_unit #(
    parameter int ROT0 = 9,
    parameter int ROT1 = 5,
    parameter int ROT2 = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [127:0] X_IN,
    input  logic [191:0] RK,
    output logic [127:0] X_OUT,
    output logic         BUSY,
    output logic         DONE
);

    localparam int R0 = ROT0 % 32;
    localparam int R1 = ROT1 % 32;
    localparam int R2 = ROT2 % 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD0 = 2'd1;
    localparam logic [1:0] S_ADD1 = 2'd2;
    localparam logic [1:0] S_ADD2 = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [127:0] x_cap_q, x_cap_d;
    logic [191:0] rk_cap_q, rk_cap_d;
    logic [31:0]  y0_q, y0_d;
    logic [31:0]  y1_q, y1_d;
    logic [127:0] x_out_q, x_out_d;
    logic         done_q, done_d;

    logic [31:0]  add_a, add_b, add_sum;
    logic         carry;

    // A shift by 32 yields zero, so an amount of 0 falls out as the identity.
    function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    always_comb begin
        add_a = 32'h0;
        add_b = 32'h0;
        case (state_q)
            S_ADD0: begin
                add_a = x_cap_q[31:0]  ^ rk_cap_q[31:0];
                add_b = x_cap_q[63:32] ^ rk_cap_q[63:32];
            end
            S_ADD1: begin
                add_a = x_cap_q[63:32] ^ rk_cap_q[95:64];
                add_b = x_cap_q[95:64] ^ rk_cap_q[127:96];
            end
            S_ADD2: begin
                add_a = x_cap_q[95:64]  ^ rk_cap_q[159:128];
                add_b = x_cap_q[127:96] ^ rk_cap_q[191:160];
            end
            default: ;
        endcase
    end

    // Full-adder chain, carry-in 0; the final carry-out is dropped (mod 2^32).
    always_comb begin
        carry   = 1'b0;
        add_sum = 32'h0;
        for (int i = 0; i < 32; i++) begin
            add_sum[i] = add_a[i] ^ add_b[i] ^ carry;
            carry      = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
        end
    end

    always_comb begin
        state_d  = state_q;
        x_cap_d  = x_cap_q;
        rk_cap_d = rk_cap_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        x_out_d  = x_out_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    x_cap_d  = X_IN;
                    rk_cap_d = RK;
                    state_d  = S_ADD0;
                end
            end
            S_ADD0: begin
                y0_d    = rol32(add_sum, R0);
                state_d = S_ADD1;
            end
            S_ADD1: begin
                y1_d    = ror32(add_sum, R1);
                state_d = S_ADD2;
            end
            S_ADD2: begin
                x_out_d = {x_cap_q[31:0], ror32(add_sum, R2), y1_q, y0_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            x_cap_q  <= 128'h0;
            rk_cap_q <= 192'h0;
            y0_q     <= 32'h0;
            y1_q     <= 32'h0;
            x_out_q  <= 128'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_cap_q  <= x_cap_d;
            rk_cap_q <= rk_cap_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            x_out_q  <= x_out_d;
            done_q   <= done_d;
        end
    end

    assign X_OUT = x_out_q;
    assign BUSY  = (state_q != S_IDLE);
    assign DONE  = done_q;

endmodule

// File: tb/tb_lea_round_unit.sv
// Self-checking bench: default-rotation DUT and a swept-rotation DUT share stimulus.
module tb_lea_round_unit;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [127:0] X_IN;
    logic [191:0] RK;
    logic [127:0] x_out_a, x_out_b;
    logic         busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    lea_round_unit dut_a (
        .CLK(CLK), .RST(RST), .START(START), .X_IN(X_IN), .RK(RK),
        .X_OUT(x_out_a), .BUSY(busy_a), .DONE(done_a)
    );

    lea_round_unit #(.ROT0(0), .ROT1(31), .ROT2(16)) dut_b (
        .CLK(CLK), .RST(RST), .START(START), .X_IN(X_IN), .RK(RK),
        .X_OUT(x_out_b), .BUSY(busy_b), .DONE(done_b)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] m_rol(input logic [31:0] v, input int n);
        logic [63:0] t;
        int m;
        m = n % 32;
        t = {v, v};
        return t[63-m -: 32];
    endfunction

    function automatic logic [31:0] m_ror(input logic [31:0] v, input int n);
        return m_rol(v, (32 - (n % 32)) % 32);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] x, input logic [191:0] rk,
                                           input int r0, input int r1, input int r2);
        logic [31:0] xw [4];
        logic [31:0] kw [6];
        logic [31:0] y0, y1, y2;
        for (int i = 0; i < 4; i++) xw[i] = x[32*i +: 32];
        for (int i = 0; i < 6; i++) kw[i] = rk[32*i +: 32];
        y0 = m_rol(32'((64'(xw[0] ^ kw[0]) + 64'(xw[1] ^ kw[1])) % 64'h1_0000_0000), r0);
        y1 = m_ror(32'((64'(xw[1] ^ kw[2]) + 64'(xw[2] ^ kw[3])) % 64'h1_0000_0000), r1);
        y2 = m_ror(32'((64'(xw[2] ^ kw[4]) + 64'(xw[3] ^ kw[5])) % 64'h1_0000_0000), r2);
        return {xw[0], y2, y1, y0};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issues one round from IDLE and checks the full latency profile of both DUTs.
    task automatic run_round(input logic [127:0] x, input logic [191:0] rk, input string nm);
        logic [127:0] ea, eb;
        ea = model(x, rk, 9, 5, 3);
        eb = model(x, rk, 0, 31, 16);
        X_IN = x; RK = rk; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        X_IN = rand128(); RK = rand192();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_phase%0d: busy=%b done=%b required busy=1 done=0", nm, i, busy_a, done_a);
            end
            if (i < 2) begin
                @(posedge CLK); #1;
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL %s done_edge: done=%b busy=%b done_b=%b required 1 0 1", nm, done_a, busy_a, done_b);
        end
        checks++;
        if (x_out_a !== ea) begin
            errors++;
            $display("FAIL %s x_out: got %h required %h", nm, x_out_a, ea);
        end
        checks++;
        if (x_out_b !== eb) begin
            errors++;
            $display("FAIL %s x_out_sweep: got %h required %h", nm, x_out_b, eb);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; X_IN = '0; RK = '0;
        #12;
        checks++;
        if (x_out_a !== 128'h0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: x_out=%h busy=%b done=%b required 0 0 0", x_out_a, busy_a, done_a);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        logic [127:0] e;
        run_round(128'h0, {32'h0, 32'h20, 32'h1, 32'hFFFFFFFF, 32'h2, 32'h1}, "basic");
        e = {32'h0, 32'h4, 32'h0, 32'h600};
        checks++;
        if (x_out_a !== e) begin
            errors++;
            $display("FAIL basic_const: got %h required %h", x_out_a, e);
        end
        @(posedge CLK); #1;
        checks++;
        if (done_a !== 1'b0 || x_out_a !== e) begin
            errors++;
            $display("FAIL basic_hold: done=%b x_out=%h required done=0 x_out=%h", done_a, x_out_a, e);
        end
    endtask

    task automatic test_carry_chain();
        run_round({32'h0, 32'h0, 32'h1, 32'hFFFFFFFF}, 192'h0, "carry");
        checks++;
        if (x_out_a[31:0] !== 32'h0 || x_out_a[127:96] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL carry_y0_y3: y0=%h y3=%h required 00000000 ffffffff", x_out_a[31:0], x_out_a[127:96]);
        end
    endtask

    task automatic test_reset_mid_round();
        X_IN = rand128(); RK = rand192(); START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        #2 RST = 1'b1;
        #1;
        checks++;
        if (x_out_a !== 128'h0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: x_out=%h busy=%b done=%b required 0 0 0", x_out_a, busy_a, done_a);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (done_a !== 1'b0 || x_out_a !== 128'h0) begin
                errors++;
                $display("FAIL reset_no_done cyc%0d: done=%b x_out=%h required done=0 x_out=0", i, done_a, x_out_a);
            end
        end
        run_round(rand128(), rand192(), "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [127:0] qa[$];
        logic [127:0] qb[$];
        logic [127:0] ea, eb;
        bit exp_done;
        for (int c = 0; c < 40; c++) begin
            X_IN = rand128(); RK = rand192(); START = 1'b1;
            if (c % 4 == 0) begin
                qa.push_back(model(X_IN, RK, 9, 5, 3));
                qb.push_back(model(X_IN, RK, 0, 31, 16));
            end
            @(posedge CLK); #1;
            exp_done = (c % 4 == 3);
            checks++;
            if (done_a !== exp_done || busy_a !== !exp_done) begin
                errors++;
                $display("FAIL b2b_timing cyc%0d: done=%b busy=%b required done=%b busy=%b",
                         c, done_a, busy_a, exp_done, !exp_done);
            end
            if (exp_done && qa.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                checks++;
                if (x_out_a !== ea || x_out_b !== eb) begin
                    errors++;
                    $display("FAIL b2b_data cyc%0d: got %h / %h required %h / %h", c, x_out_a, x_out_b, ea, eb);
                end
            end
        end
        START = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_param_sweep();
        logic [127:0] e;
        run_round(128'h0, {32'h1, 32'h80000000, 32'h1, 32'h80000000, 32'h0, 32'h80000001}, "sweep");
        e = {32'h0, 32'h00018000, 32'h00000003, 32'h80000001};
        checks++;
        if (x_out_b !== e) begin
            errors++;
            $display("FAIL sweep_const: got %h required %h", x_out_b, e);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            run_round(rand128(), rand192(), "random");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_reset_mid_round();
        test_back_to_back();
        test_param_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
